// File: rtl/mem_access_controller_if.sv
// Core-side and memory-side handshake bundle for mem_access_controller.
// The slave modport is the controller's view; master is the core/memory environment.
interface mem_access_controller_if;
    logic        req_valid_i;
    logic        req_write_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        req_ready_o;
    logic        stall_o;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i,
        output req_ready_o, stall_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        output req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  req_ready_o, stall_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_controller.sv
// Load/store sequencer onto a single-ported word memory with req/ack handshake.
// Optional MEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT_CYCLES.
module mem_access_controller #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    mem_access_controller_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    function automatic logic req_ok(input logic wr, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        logic aligned;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~wr;
            default:                legal = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   aligned = (off[0] == 1'b0);
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal & aligned;
    endfunction

    function automatic logic [3:0] fmt_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] fmt_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] w;
        w = rd >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h000000, w[7:0]};
            3'b101:  return {16'h0000, w[15:0]};
            default: return w;
        endcase
    endfunction

    state_t      r_state;
    logic        r_ready;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic        w_ok;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign w_ok = req_ok(bus.req_write_i, bus.req_funct3_i, bus.req_addr_i[1:0]);

    // Accept in IDLE, hold the memory request until ack, then emit a one-cycle response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_wstrb      <= 4'b0000;
            r_wdata      <= 32'h0000_0000;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
            r_tcnt       <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_ready      <= 1'b0;
                        r_funct3     <= bus.req_funct3_i;
                        r_off        <= bus.req_addr_i[1:0];
                        r_mem_addr   <= {bus.req_addr_i[31:2], 2'b00};
                        r_mem_we     <= bus.req_write_i;
                        r_wstrb      <= bus.req_write_i ? fmt_strb(bus.req_funct3_i, bus.req_addr_i[1:0]) : 4'b0000;
                        r_wdata      <= bus.req_write_i ? fmt_wdata(bus.req_funct3_i, bus.req_wdata_i) : 32'h0000_0000;
                        r_resp_rdata <= 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
                        r_tcnt       <= '0;
`endif
                        if (w_ok) begin
                            r_mem_req  <= 1'b1;
                            r_resp_err <= 1'b0;
                            r_state    <= S_ACCESS;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    // An ack coinciding with the timeout still completes the access.
                    if (bus.mem_ack_i) begin
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_mem_we ? 32'h0000_0000 : extract(r_funct3, r_off, bus.mem_rdata_i);
                        r_state      <= S_RESP;
`ifdef MEM_TIMEOUT_EN
                    end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'h0000_0000;
                        r_state      <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
`else
                    end else begin
                        r_state <= S_ACCESS;
`endif
                    end
                end
                S_RESP: begin
                    r_ready    <= 1'b1;
                    r_resp_err <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_ready   <= 1'b1;
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = r_ready;
    assign bus.stall_o      = ((r_state == S_IDLE) & bus.req_valid_i) | (r_state == S_ACCESS);
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.resp_err_o   = r_resp_err;
    assign bus.resp_rdata_o = r_resp_rdata;
    assign bus.mem_req_o    = r_mem_req;
    assign bus.mem_we_o     = r_mem_we;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_wstrb_o  = r_wstrb;
    assign bus.mem_wdata_o  = r_wdata;
endmodule

// File: tb/tb_mem_access_controller.sv
// Randomized bench for mem_access_controller against an arithmetic reference model.
module tb_mem_access_controller;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    mem_access_controller_if bus();

    mem_access_controller #(.TIMEOUT_CYCLES(255)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: size in bytes, legality and expected memory/response fields.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic exp_ok(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        legal = wr ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return legal && ((addr % nbytes(f3)) == 0);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
        longint field;
        longint span;
        int     nb;
        nb = nbytes(f3);
        field = longint'(rd) >> (8 * (addr % 4));
        if (nb == 4) return field[31:0];
        span  = longint'(1) << (8 * nb);
        field = field % span;
        if (f3[2] == 1'b0 && field >= span / 2) field = field - span;
        return field[31:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    task automatic drive_idle();
        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = 1'($urandom);
        bus.req_funct3_i = 3'($urandom);
        bus.req_addr_i   = $urandom;
        bus.req_wdata_i  = $urandom;
    endtask

    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int dly);
        logic        ok;
        logic [3:0]  es;
        logic [31:0] ew;
        logic [31:0] er;
        ok = exp_ok(wr, f3, addr);
        es = wr ? 4'(((1 << nbytes(f3)) - 1) << (addr % 4)) : 4'b0000;
        ew = wr ? exp_wdata(f3, wd) : 32'h0000_0000;
        er = wr ? 32'h0000_0000 : exp_rdata(f3, addr, rd);

        @(negedge clk_i);
        chk("ready_idle", {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = wr;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wd;
        #1 chk("stall_accept", {31'd0, bus.stall_o}, 32'd1);
        @(posedge clk_i);
        #1 drive_idle();

        if (!ok) begin
            @(negedge clk_i);
            chk("err_memreq", {31'd0, bus.mem_req_o}, 32'd0);
            chk("err_valid", {31'd0, bus.resp_valid_o}, 32'd1);
            chk("err_flag", {31'd0, bus.resp_err_o}, 32'd1);
            chk("err_rdata", bus.resp_rdata_o, 32'd0);
            chk("err_stall", {31'd0, bus.stall_o}, 32'd0);
        end else begin
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk_i);
                chk("acc_req", {31'd0, bus.mem_req_o}, 32'd1);
                chk("acc_addr", bus.mem_addr_o, {addr[31:2], 2'b00});
                chk("acc_we", {31'd0, bus.mem_we_o}, {31'd0, wr});
                chk("acc_strb", {28'd0, bus.mem_wstrb_o}, {28'd0, es});
                if (wr) chk("acc_wdata", bus.mem_wdata_o, ew);
                chk("acc_stall", {31'd0, bus.stall_o}, 32'd1);
                chk("acc_novalid", {31'd0, bus.resp_valid_o}, 32'd0);
                bus.mem_ack_i   = (k == dly);
                bus.mem_rdata_i = (k == dly) ? rd : $urandom;
            end
            @(negedge clk_i);
            bus.mem_ack_i = 1'b0;
            chk("rsp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
            chk("rsp_err", {31'd0, bus.resp_err_o}, 32'd0);
            chk("rsp_rdata", bus.resp_rdata_o, er);
            chk("rsp_memreq", {31'd0, bus.mem_req_o}, 32'd0);
            chk("rsp_stall", {31'd0, bus.stall_o}, 32'd0);
        end
        // A stray ack during RESP must not create a second response.
        bus.mem_ack_i   = 1'($urandom);
        bus.mem_rdata_i = $urandom;
        @(negedge clk_i);
        bus.mem_ack_i = 1'b0;
        chk("post_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("post_memreq", {31'd0, bus.mem_req_o}, 32'd0);
        chk("post_ready", {31'd0, bus.req_ready_o}, 32'd1);
    endtask

    initial begin
        drive_idle();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rst_memreq", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, bus.mem_we_o}, 32'd0);
        chk("rst_strb", {28'd0, bus.mem_wstrb_o}, 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'd0);
        chk("rst_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("rst_err", {31'd0, bus.resp_err_o}, 32'd0);
        chk("rst_rdata", bus.resp_rdata_o, 32'd0);

        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0);
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF1234, 0);
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF1234, 1);
        run_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF1234, 0);
        run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF1234, 2);
        run_txn(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0,       0);
        run_txn(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0,       0);
        run_txn(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,       5);
        run_txn(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0);
        run_txn(1'b1, 3'b100, 32'h0000_0200, 32'h0,        32'h0,        0);
        run_txn(1'b0, 3'b011, 32'h0000_0200, 32'h0,        32'h0,        0);

        for (int t = 0; t < 300; t++)
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));

        // Reset while waiting for ack: no response, late ack ignored.
        @(negedge clk_i);
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = 1'b0;
        bus.req_funct3_i = 3'b010;
        bus.req_addr_i   = 32'h0000_0400;
        @(posedge clk_i);
        #1 drive_idle();
        repeat (3) @(negedge clk_i);
        chk("mid_req", {31'd0, bus.mem_req_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("mid_rst_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        bus.mem_ack_i = 1'b0;
        chk("late_ack_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("late_ack_ready", {31'd0, bus.req_ready_o}, 32'd1);
        run_txn(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_controller.md
# mem_access_controller

Sequences load/store instructions from the core onto a single-ported, word-wide data memory with a request/acknowledge handshake. It stalls the core while an access is in flight. For stores it generates byte strobes and lane-replicated write data. For loads it extracts and sign/zero-extends the read data. It sits between the decode/control stage (which supplies funct3, the address and the store data) and the data memory, and reports misaligned or illegal accesses as errors.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255 — maximum cycles spent in ACCESS waiting for mem_ack_i (used only with MEM_TIMEOUT_EN).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  core presents a load/store.
- req_write_i  input  1  1 = store, 0 = load.
- req_funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data; value in the low bits.
- req_ready_o  output  1  high in IDLE only.
- stall_o  output  1  hold the core pipeline.
- resp_valid_o  output  1  one-cycle response pulse.
- resp_rdata_o  output  32  extended load data; 0 for stores and errors.
- resp_err_o  output  1  qualified by resp_valid_o: misaligned, illegal funct3, or timeout.
- mem_req_o  output  1  memory request, held until acknowledged.
- mem_we_o  output  1  write enable.
- mem_addr_o  output  32  word-aligned address, {req_addr_i[31:2], 2'b00}.
- mem_wstrb_o  output  4  byte strobes (0000 on loads).
- mem_wdata_o  output  32  lane-replicated write data.
- mem_ack_i  input  1  memory completes the access this cycle.
- mem_rdata_i  input  32  read word, valid with mem_ack_i.

## Operation
- FSM with three states: IDLE, ACCESS, RESP.
- IDLE: a request is accepted when req_valid_i is high. On acceptance, addr, funct3, write and the formatted wdata/strobes are registered.
  - Legal and aligned request → ACCESS.
  - Illegal or misaligned request → RESP with error. No memory access is issued.
- Legal funct3 for loads: 000, 001, 010, 100, 101. For stores: 000, 001, 010. Any other value is illegal.
- Alignment rules: H/HU requires addr[0]=0. W requires addr[1:0]=00. B/BU is always aligned.
- Store strobes:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
- Store data: byte replicated ×4, halfword replicated ×2, word unchanged.
- ACCESS: mem_req_o=1. mem_addr_o, mem_we_o, mem_wstrb_o and mem_wdata_o stay stable until mem_ack_i is sampled high; then → RESP.
- Load extraction: the field is (mem_rdata_i >> 8*addr[1:0]), truncated to the access size.
  - B and H are sign-extended.
  - BU and HU are zero-extended.
  - W passes through unchanged.
- The extracted result is registered into resp_rdata_o on the ack edge.
- RESP: resp_valid_o=1 for exactly one cycle, then → IDLE. Any mem_ack_i outside ACCESS is ignored.
- stall_o = (IDLE & req_valid_i) | ACCESS. stall_o is low in RESP so the core advances with the response.

## Timing
- Reset values: state IDLE. req_ready_o=1. All other outputs are 0, including stall_o when req_valid_i=0.
- Accept at edge N → mem_req_o high in cycle N+1.
- mem_ack_i sampled high at edge M → resp_valid_o high in cycle M+1. Minimum latency from accept to response is 2 cycles (zero-wait memory).
- Error path: accept at edge N → resp_valid_o with resp_err_o=1 in cycle N+1.
- A new request can be accepted in the cycle after RESP, giving 3-cycle minimum throughput.
- Reset during ACCESS: on that edge, mem_req_o drops and state returns to IDLE. No response is generated, and a late ack is ignored.
- req_* inputs are only sampled on the acceptance edge; later changes have no effect.

## Configuration
- MEM_TIMEOUT_EN defined: a counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - Reaching TIMEOUT_CYCLES → mem_req_o drops, state → RESP with resp_err_o=1 and resp_rdata_o=0.
  - An ack in the same cycle as the timeout wins.
- MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely. No counter is built and TIMEOUT_CYCLES is unused.

## Test plan
- Zero-wait LW, addr 0x100, mem_rdata_i 0xDEADBEEF → mem_addr_o 0x100, mem_wstrb_o 0000; resp_valid_o 2 cycles after accept with resp_rdata_o 0xDEADBEEF, resp_err_o 0.
- LB at 0x103, rdata 0x80FF1234 → resp_rdata_o 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB at 0x201 with wdata 0x000000AB → mem_addr_o 0x200, mem_wstrb_o 0010, mem_wdata_o 0xABABABAB, mem_we_o 1. SH at 0x202 with wdata 0x1234 → strobes 1100, wdata 0x12341234.
- Misaligned LW at 0x102, and a store with funct3 100 → no mem_req_o; resp_err_o=1 one cycle after accept.
- Ack delayed 5 cycles → mem_addr_o and mem_wdata_o stable throughout and stall_o high. Assert rst_i mid-wait → IDLE next cycle, no resp_valid_o.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never arrives → mem_req_o drops after 4 ACCESS cycles and resp_err_o=1.
